// File: rtl/pw_buffer_reader.sv
// rtl/pw_buffer_reader.sv - inter-stage buffer reader feeding the 1x1 pointwise PE cluster
//
// Reads each pixel's WORDS_PER_PIXEL packed words once per output-channel group
// (OC_GROUPS passes, back to back), drives the matching weight addresses, clears the
// PE accumulators on word 0 of every group and flags each finished group two cycles
// after its last word is addressed (one cycle of buffer read latency plus one of PE
// accumulation). A pixel's words are credited back to the writer only after every
// group has consumed them.
//
// Optional feature macro: PW_READER_OVF_CHECK_EN (sticky overflow error, saturating count).
//
// Ports:
//   clk               in   sole clock
//   reset             in   synchronous active-high reset
//   start             in   one-cycle layer start pulse (ignored unless idle)
//   wr_word_done      in   writer committed one word to the buffer this cycle
//   addr_ram_next_rd  out  buffer read address
//   addr_w_n_state    out  weight read address
//   PE_reset_n_state  out  accumulator clear for the 4 PEs
//   ofm_valid         out  group result valid pulse
//   ofm_group         out  group index of the valid result
//   pixel_release     out  credit pulse freeing WORDS_PER_PIXEL words
//   buf_count         out  words currently held in the buffer
//   buf_full          out  buf_count == BUF_DEPTH
//   busy              out  layer in progress
//   done              out  layer complete pulse
//   err               out  sticky protocol error
module pw_buffer_reader #(
    parameter int WORDS_PER_PIXEL = 4,
    parameter int OC_GROUPS       = 8,
    parameter int NUM_PIXELS      = 2916,
    parameter int BUF_DEPTH       = 64,
    parameter int W_BASE          = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         wr_word_done,
    output logic [31:0]                  addr_ram_next_rd,
    output logic [31:0]                  addr_w_n_state,
    output logic [3:0]                   PE_reset_n_state,
    output logic                         ofm_valid,
    output logic [$clog2(OC_GROUPS)-1:0] ofm_group,
    output logic                         pixel_release,
    output logic [$clog2(BUF_DEPTH):0]   buf_count,
    output logic                         buf_full,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int KW = (WORDS_PER_PIXEL > 1) ? $clog2(WORDS_PER_PIXEL) : 1;
    localparam int GW = (OC_GROUPS > 1) ? $clog2(OC_GROUPS) : 1;
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int PW = $clog2(NUM_PIXELS + 1);

    localparam logic [KW-1:0] K_LAST   = KW'(WORDS_PER_PIXEL - 1);
    localparam logic [KW-1:0] K_ONE    = KW'(1);
    localparam logic [GW-1:0] G_LAST   = GW'(OC_GROUPS - 1);
    localparam logic [GW-1:0] G_ONE    = GW'(1);
    localparam logic [PW-1:0] P_LAST   = PW'(NUM_PIXELS - 1);
    localparam logic [PW-1:0] P_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_WPP  = CW'(WORDS_PER_PIXEL);
    localparam logic [CW-1:0] CNT_FULL = CW'(BUF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [GW-1:0] g_q, g_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Two-stage valid/group pipeline: read latency then accumulate latency.
    logic          v1_q, v2_q;
    logic [GW-1:0] gp1_q, gp2_q;

    logic          in_read;
    logic          first_word;
    logic          last_word;
    logic          release_c;
    logic          done_c;
    logic [31:0]   base_sum;
    logic [31:0]   rd_sum;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        g_d        = g_q;
        pix_d      = pix_q;
        base_d     = base_q;
        in_read    = 1'b0;
        first_word = 1'b0;
        last_word  = 1'b0;
        release_c  = 1'b0;
        done_c     = 1'b0;
        base_sum   = 32'(base_q) + 32'(WORDS_PER_PIXEL);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    pix_d   = '0;
                    g_d     = '0;
                    k_d     = '0;
                end
            end
            S_WAIT: begin
                if (cnt_q >= CNT_WPP) begin
                    state_d = S_READ;
                    g_d     = '0;
                    k_d     = '0;
                end
            end
            S_READ: begin
                in_read    = 1'b1;
                first_word = (k_q == '0);
                if (k_q == K_LAST) begin
                    last_word = 1'b1;
                    k_d       = '0;
                    if (g_q == G_LAST) begin
                        g_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        g_d = g_q + G_ONE;
                    end
                end else begin
                    k_d = k_q + K_ONE;
                end
            end
            S_DRAIN: begin
                // Every group has now read this pixel, so its words can be freed.
                release_c = 1'b1;
                base_d    = (base_sum >= 32'(BUF_DEPTH)) ? '0 : base_sum[AW-1:0];
                pix_d     = pix_q + P_ONE;
                state_d   = (pix_q == P_LAST) ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef PW_READER_OVF_CHECK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        cnt_d = cnt_q;
`ifdef PW_READER_OVF_CHECK_EN
        err_d = err_q;
`endif
        case ({wr_word_done, release_c})
            2'b10: begin
`ifdef PW_READER_OVF_CHECK_EN
                // A write into a full buffer with no same-cycle credit is an overflow.
                if (cnt_q == CNT_FULL) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
`else
                cnt_d = cnt_q + CNT_ONE;
`endif
            end
            2'b01:   cnt_d = cnt_q - CNT_WPP;
            2'b11:   cnt_d = cnt_q + CNT_ONE - CNT_WPP;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            g_q     <= '0;
            pix_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            gp1_q   <= '0;
            gp2_q   <= '0;
`ifdef PW_READER_OVF_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            g_q     <= g_d;
            pix_q   <= pix_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            v1_q    <= last_word;
            v2_q    <= v1_q;
            gp1_q   <= g_q;
            gp2_q   <= gp1_q;
`ifdef PW_READER_OVF_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // rd_base is always a multiple of WORDS_PER_PIXEL, but wrap anyway so any
    // base/word combination stays inside the ring.
    assign rd_sum = 32'(base_q) + 32'(k_q);

    // Outputs are forced low while reset is held so nothing stale leaks out
    // during the reset cycle itself.
    assign addr_ram_next_rd = (in_read && !reset)
                            ? ((rd_sum >= 32'(BUF_DEPTH)) ? rd_sum - 32'(BUF_DEPTH) : rd_sum)
                            : 32'd0;
    assign addr_w_n_state   = (in_read && !reset)
                            ? 32'(W_BASE) + 32'(g_q) * 32'(WORDS_PER_PIXEL) + 32'(k_q)
                            : 32'd0;
    assign PE_reset_n_state = (first_word && !reset) ? 4'hF : 4'h0;
    assign ofm_valid        = v2_q && !reset;
    assign ofm_group        = (v2_q && !reset) ? gp2_q : '0;
    assign pixel_release    = release_c && !reset;
    assign buf_count        = reset ? '0 : cnt_q;
    assign buf_full         = !reset && (cnt_q == CNT_FULL);
    assign busy             = !reset && (state_q != S_IDLE);
    assign done             = done_c && !reset;
`ifdef PW_READER_OVF_CHECK_EN
    assign err              = err_q && !reset;
`else
    assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_pw_buffer_reader.sv
// tb/tb_pw_buffer_reader.sv - self-checking bench for pw_buffer_reader
module tb_pw_buffer_reader;

    localparam int WPP  = 4;
    localparam int OCG  = 8;
    localparam int NPIX = 5;
    localparam int BD   = 8;
    localparam int WB   = 16;
    localparam int MAXC = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        wr_word_done;
    logic [31:0] addr_ram_next_rd;
    logic [31:0] addr_w_n_state;
    logic [3:0]  PE_reset_n_state;
    logic        ofm_valid;
    logic [2:0]  ofm_group;
    logic        pixel_release;
    logic [3:0]  buf_count;
    logic        buf_full;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    int exp_rd   [MAXC];
    int exp_w    [MAXC];
    int exp_grp  [MAXC];
    bit exp_pe   [MAXC];
    bit exp_ofm  [MAXC];
    bit exp_rel  [MAXC];
    bit exp_done [MAXC];

    wire [80:0] all_out = {addr_ram_next_rd, addr_w_n_state, PE_reset_n_state, ofm_valid,
                           ofm_group, pixel_release, buf_count, buf_full, busy, done, err};

    always #5 clk = ~clk;

    pw_buffer_reader #(
        .WORDS_PER_PIXEL(WPP),
        .OC_GROUPS      (OCG),
        .NUM_PIXELS     (NPIX),
        .BUF_DEPTH      (BD),
        .W_BASE         (WB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .wr_word_done    (wr_word_done),
        .addr_ram_next_rd(addr_ram_next_rd),
        .addr_w_n_state  (addr_w_n_state),
        .PE_reset_n_state(PE_reset_n_state),
        .ofm_valid       (ofm_valid),
        .ofm_group       (ofm_group),
        .pixel_release   (pixel_release),
        .buf_count       (buf_count),
        .buf_full        (buf_full),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset        = 1'b1;
        start        = 1'b0;
        wr_word_done = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        start        = 1'b0;
        wr_word_done = 1'b1;
        tick;
        checks++;
        if (all_out !== 81'd0) begin
            errors++;
            $display("FAIL reset_during outputs got %h exp 0", all_out);
        end
        wr_word_done = 1'b0;
        tick;
        reset = 1'b0;
        tick;
        tick;
        checks++;
        if (all_out !== 81'd0) begin
            errors++;
            $display("FAIL reset_after outputs got %h exp 0", all_out);
        end
    endtask

    // Whole-layer run against a schedule model: once a pixel is available while
    // waiting, its 32 reads follow on consecutive cycles, each group's result two
    // cycles after its last word, credit right after the last group, done one later.
    task automatic test_stream(input string name, input int prefill, input int period, input int prob);
        int  s, wait_entry, pix, c0, done_c, mcount, written, base, n_ofm;
        bit  waiting, finished, want, wr;
        do_reset;
        for (int i = 0; i < MAXC; i++) begin
            exp_rd[i] = 0; exp_w[i] = 0; exp_grp[i] = 0;
            exp_pe[i] = 0; exp_ofm[i] = 0; exp_rel[i] = 0; exp_done[i] = 0;
        end
        s = prefill; wait_entry = s + 1; pix = 0; done_c = MAXC + 10;
        mcount = 0; written = 0; n_ofm = 0; waiting = 1'b1; finished = 1'b0;
        for (int n = 0; n < MAXC - 40; n++) begin
            checks++;
            if (addr_ram_next_rd !== 32'(exp_rd[n])) begin
                errors++;
                $display("FAIL %s rd_addr cyc %0d got %0d exp %0d", name, n, addr_ram_next_rd, exp_rd[n]);
            end
            checks++;
            if (addr_w_n_state !== 32'(exp_w[n])) begin
                errors++;
                $display("FAIL %s w_addr cyc %0d got %0d exp %0d", name, n, addr_w_n_state, exp_w[n]);
            end
            checks++;
            if (PE_reset_n_state !== (exp_pe[n] ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL %s pe_reset cyc %0d got %h exp %0d", name, n, PE_reset_n_state, exp_pe[n]);
            end
            checks++;
            if (ofm_valid !== exp_ofm[n]) begin
                errors++;
                $display("FAIL %s ofm_valid cyc %0d got %b exp %b", name, n, ofm_valid, exp_ofm[n]);
            end
            if (ofm_valid === 1'b1) n_ofm++;
            if (exp_ofm[n]) begin
                checks++;
                if (ofm_group !== 3'(exp_grp[n])) begin
                    errors++;
                    $display("FAIL %s ofm_group cyc %0d got %0d exp %0d", name, n, ofm_group, exp_grp[n]);
                end
            end
            checks++;
            if (pixel_release !== exp_rel[n]) begin
                errors++;
                $display("FAIL %s release cyc %0d got %b exp %b", name, n, pixel_release, exp_rel[n]);
            end
            checks++;
            if (done !== exp_done[n]) begin
                errors++;
                $display("FAIL %s done cyc %0d got %b exp %b", name, n, done, exp_done[n]);
            end
            checks++;
            if (busy !== (n >= s + 1 && n <= done_c)) begin
                errors++;
                $display("FAIL %s busy cyc %0d got %b", name, n, busy);
            end
            checks++;
            if (buf_count !== 4'(mcount) || buf_full !== (mcount == BD) || err !== 1'b0) begin
                errors++;
                $display("FAIL %s count cyc %0d got %0d/%b/%b exp %0d", name, n, buf_count, buf_full, err, mcount);
            end
            if (n > done_c + 3) begin
                finished = 1'b1;
                break;
            end
            if (waiting && n >= wait_entry && mcount >= WPP) begin
                c0   = n + 1;
                base = (pix * WPP) % BD;
                for (int j = 0; j < WPP * OCG; j++) begin
                    exp_rd[c0 + j] = (base + j % WPP) % BD;
                    exp_w[c0 + j]  = WB + j;
                    exp_pe[c0 + j] = (j % WPP == 0);
                    if (j % WPP == WPP - 1) begin
                        exp_ofm[c0 + j + 2] = 1'b1;
                        exp_grp[c0 + j + 2] = j / WPP;
                    end
                end
                exp_rel[c0 + WPP * OCG] = 1'b1;
                pix++;
                if (pix == NPIX) begin
                    done_c           = c0 + WPP * OCG + 1;
                    exp_done[done_c] = 1'b1;
                    waiting          = 1'b0;
                end else begin
                    wait_entry = c0 + WPP * OCG + 1;
                end
            end
            wr = 1'b0;
            if (n < prefill) begin
                wr = 1'b1;
            end else if (n > s && written < NPIX * WPP) begin
                want = (period > 0) ? (n % period == 0) : ($urandom_range(0, 99) < prob);
                if (want && mcount + 1 - (exp_rel[n] ? WPP : 0) <= BD) wr = 1'b1;
            end
            if (wr) written++;
            mcount       = mcount + (wr ? 1 : 0) - (exp_rel[n] ? WPP : 0);
            wr_word_done = wr;
            start        = (n == s);
            tick;
        end
        wr_word_done = 1'b0;
        start        = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout layer never completed", name);
        end
        checks++;
        if (n_ofm != NPIX * OCG || buf_count !== 4'd0) begin
            errors++;
            $display("FAIL %s totals ofm %0d exp %0d count %0d exp 0", name, n_ofm, NPIX * OCG, buf_count);
        end
    endtask

    task automatic test_same_cycle;
        int cyc;
        do_reset;
        for (int i = 0; i < 5; i++) begin
            wr_word_done = 1'b1;
            start        = (i == 4);
            tick;
        end
        wr_word_done = 1'b0;
        start        = 1'b0;
        cyc = 5;
        while (pixel_release !== 1'b1 && cyc < 200) begin
            tick;
            cyc++;
        end
        checks++;
        if (cyc != 38 || buf_count !== 4'd5) begin
            errors++;
            $display("FAIL same_cycle release_at got %0d/%0d exp 38/5", cyc, buf_count);
        end
        wr_word_done = 1'b1;
        tick;
        wr_word_done = 1'b0;
        checks++;
        if (buf_count !== 4'd2) begin
            errors++;
            $display("FAIL same_cycle net_count got %0d exp 2", buf_count);
        end
    endtask

    task automatic test_mid_reset;
        int pe_seen, cyc;
        do_reset;
        for (int i = 0; i < 5; i++) begin
            wr_word_done = (i < 4);
            start        = (i == 4);
            tick;
        end
        wr_word_done = 1'b0;
        start        = 1'b0;
        pe_seen = 0;
        cyc     = 0;
        while (pe_seen < 4 && cyc < 200) begin
            if (PE_reset_n_state === 4'hF) pe_seen++;
            if (pe_seen < 4) begin
                tick;
                cyc++;
            end
        end
        checks++;
        if (pe_seen != 4 || addr_w_n_state !== 32'(WB + 3 * WPP)) begin
            errors++;
            $display("FAIL mid_reset group3 got pe %0d w %0d exp 4/%0d", pe_seen, addr_w_n_state, WB + 3 * WPP);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (all_out !== 81'd0) begin
            errors++;
            $display("FAIL mid_reset during got %h exp 0", all_out);
        end
        tick;
        reset = 1'b0;
        checks++;
        if (all_out !== 81'd0) begin
            errors++;
            $display("FAIL mid_reset after got %h exp 0", all_out);
        end
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++;
            if (ofm_valid !== 1'b0 || busy !== 1'b0 || buf_count !== 4'd0) begin
                errors++;
                $display("FAIL mid_reset quiet cyc %0d got v%b b%b c%0d exp 0", i, ofm_valid, busy, buf_count);
            end
        end
    endtask

    task automatic test_overflow;
        do_reset;
        wr_word_done = 1'b1;
        for (int i = 0; i < BD; i++) tick;
        wr_word_done = 1'b0;
        checks++;
        if (buf_full !== 1'b1 || buf_count !== 4'(BD)) begin
            errors++;
            $display("FAIL overflow fill got full %b count %0d exp 1/%0d", buf_full, buf_count, BD);
        end
        wr_word_done = 1'b1;
        tick;
        wr_word_done = 1'b0;
        tick;
`ifdef PW_READER_OVF_CHECK_EN
        checks++;
        if (err !== 1'b1 || buf_count !== 4'(BD)) begin
            errors++;
            $display("FAIL overflow err got %b count %0d exp 1/%0d", err, buf_count, BD);
        end
        tick;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL overflow sticky got %b exp 1", err);
        end
`else
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL overflow err_tied got %b exp 0", err);
        end
`endif
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        wr_word_done = 1'b0;
        test_reset;
        test_stream("prefill4", 4, 0, 100);
        test_stream("trickle3", 0, 3, 0);
        test_stream("random_a", int'($urandom_range(0, 8)), 0, 40);
        test_stream("random_b", int'($urandom_range(0, 8)), 0, 15);
        test_same_cycle;
        test_mid_reset;
        test_overflow;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
